// File: rtl/sram_bank.sv
// Storage bank of DEPTH x WIDTH cells behind a request/response handshake.
// Each request is sequenced through precharge, one-hot word-line access and respond phases.
module sram_bank #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WIDTH-1:0]  req_wdata,
  input  logic [WIDTH-1:0]  req_wmask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_rdata,
  output logic              rsp_err,
  output logic [DEPTH-1:0]  word_line
);

  typedef enum logic [1:0] {StIdle, StPrecharge, StAccess, StRespond} stateT;

  stateT             stateQ, stateD;
  logic              rwQ;
  logic [ADDR_W-1:0] addrQ;
  logic [WIDTH-1:0]  wdataQ, wmaskQ;
  logic              errQ;
  logic [WIDTH-1:0]  rdataQ;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic              addrOob;
  logic [WIDTH-1:0]  curWord;
  logic [WIDTH-1:0]  mergedWord;

  // One extra bit so DEPTH == 2**ADDR_W is still representable.
  assign addrOob = {1'b0, addrQ} >= (ADDR_W + 1)'(DEPTH);

  always_comb begin
    curWord = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (addrQ == ADDR_W'(i)) curWord = mem[i];
    end
  end

  // Reads return the stored word, writes return the post-merge word.
  assign mergedWord = rwQ ? ((curWord & ~wmaskQ) | (wdataQ & wmaskQ)) : curWord;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stateQ <= StIdle;
    else     stateQ <= stateD;
  end

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle:      if (req_valid) stateD = StPrecharge;
      StPrecharge: stateD = addrOob ? StRespond : StAccess;
      StAccess:    stateD = StRespond;
      StRespond:   if (rsp_ready) stateD = StIdle;
      default:     stateD = StIdle;
    endcase
  end

  always_comb begin
    req_ready = (stateQ == StIdle);
    rsp_valid = (stateQ == StRespond);
    word_line = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      word_line[i] = (stateQ == StAccess) && (addrQ == ADDR_W'(i));
    end
  end

  assign rsp_rdata = rdataQ;
  assign rsp_err   = errQ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rwQ    <= 1'b0;
      addrQ  <= '0;
      wdataQ <= '0;
      wmaskQ <= '0;
      errQ   <= 1'b0;
      rdataQ <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (stateQ == StIdle && req_valid) begin
        rwQ    <= req_rw;
        addrQ  <= req_addr;
        wdataQ <= req_wdata;
        wmaskQ <= req_wmask;
      end
      if (stateQ == StPrecharge) begin
        errQ   <= addrOob;
        rdataQ <= '0;
      end
      if (stateQ == StAccess) begin
        rdataQ <= mergedWord;
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (word_line[i] && rwQ) mem[i] <= mergedWord;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_bank.sv
// Directed bench for sram_bank: a 16-word bank and a 12-word bank (for out-of-range
// addresses) share one request bus, selected by sel.
module tb_sram_bank;

  logic        clk, rst;
  logic        sel;
  logic        reqValid, reqRw, rspReady;
  logic [3:0]  reqAddr;
  logic [7:0]  reqWdata, reqWmask;

  logic        rdy16, rv16, re16, rdy12, rv12, re12;
  logic [7:0]  rd16, rd12;
  logic [15:0] wl16;
  logic [11:0] wl12;

  logic        obsReady, obsValid, obsErr;
  logic [7:0]  obsData;
  logic [15:0] obsWl;

  int errors = 0;
  int checks = 0;

  sram_bank #(.WIDTH(8), .DEPTH(16), .ADDR_W(4)) dut16 (
    .clk(clk), .rst(rst),
    .req_valid(reqValid & ~sel), .req_ready(rdy16), .req_rw(reqRw), .req_addr(reqAddr),
    .req_wdata(reqWdata), .req_wmask(reqWmask),
    .rsp_valid(rv16), .rsp_ready(rspReady), .rsp_rdata(rd16), .rsp_err(re16),
    .word_line(wl16)
  );

  sram_bank #(.WIDTH(8), .DEPTH(12), .ADDR_W(4)) dut12 (
    .clk(clk), .rst(rst),
    .req_valid(reqValid & sel), .req_ready(rdy12), .req_rw(reqRw), .req_addr(reqAddr),
    .req_wdata(reqWdata), .req_wmask(reqWmask),
    .rsp_valid(rv12), .rsp_ready(rspReady), .rsp_rdata(rd12), .rsp_err(re12),
    .word_line(wl12)
  );

  assign obsReady = sel ? rdy12 : rdy16;
  assign obsValid = sel ? rv12 : rv16;
  assign obsErr   = sel ? re12 : re16;
  assign obsData  = sel ? rd12 : rd16;
  assign obsWl    = sel ? {4'b0, wl12} : wl16;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction with rsp_ready held high; checks every phase.
  task automatic xact(input logic rw, input logic [3:0] addr, input logic [7:0] wdata,
                      input logic [7:0] wmask, input logic [7:0] expData, input logic expErr,
                      input logic [15:0] expWl, input string tag);
    @(negedge clk);
    reqValid = 1'b1; reqRw = rw; reqAddr = addr; reqWdata = wdata; reqWmask = wmask;
    check({tag, "_idle_ready"}, 32'(obsReady), 32'd1);
    @(negedge clk);
    reqValid = 1'b0;
    check({tag, "_pre_wl"}, 32'(obsWl), 32'd0);
    check({tag, "_pre_ready"}, 32'(obsReady), 32'd0);
    check({tag, "_pre_valid"}, 32'(obsValid), 32'd0);
    if (!expErr) begin
      @(negedge clk);
      check({tag, "_acc_wl"}, 32'(obsWl), 32'(expWl));
      check({tag, "_acc_valid"}, 32'(obsValid), 32'd0);
    end
    @(negedge clk);
    check({tag, "_rsp_valid"}, 32'(obsValid), 32'd1);
    check({tag, "_rsp_data"}, 32'(obsData), 32'(expData));
    check({tag, "_rsp_err"}, 32'(obsErr), 32'(expErr));
    check({tag, "_rsp_wl"}, 32'(obsWl), 32'd0);
    @(negedge clk);
    check({tag, "_end_ready"}, 32'(obsReady), 32'd1);
    check({tag, "_end_valid"}, 32'(obsValid), 32'd0);
  endtask

  initial begin
    sel = 1'b0; reqValid = 1'b0; reqRw = 1'b0; reqAddr = '0;
    reqWdata = '0; reqWmask = '0; rspReady = 1'b1; rst = 1'b0;

    // Reset asserted mid-cycle takes effect immediately.
    #2 rst = 1'b1;
    #1;
    check("rst_ready16", 32'(rdy16), 32'd1);
    check("rst_valid16", 32'(rv16), 32'd0);
    check("rst_data16", 32'(rd16), 32'd0);
    check("rst_err16", 32'(re16), 32'd0);
    check("rst_wl16", 32'(wl16), 32'd0);
    check("rst_ready12", 32'(rdy12), 32'd1);
    check("rst_valid12", 32'(rv12), 32'd0);
    check("rst_wl12", 32'(wl12), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      xact(1'b0, 4'(i), 8'h00, 8'h00, 8'h00, 1'b0, 16'(1 << i), "rst_read");
    end

    xact(1'b1, 4'd3, 8'h55, 8'hFF, 8'h55, 1'b0, 16'h0008, "wr3");
    xact(1'b0, 4'd3, 8'h00, 8'h00, 8'h55, 1'b0, 16'h0008, "rd3");
    xact(1'b0, 4'd4, 8'h00, 8'h00, 8'h00, 1'b0, 16'h0010, "rd4");
    xact(1'b1, 4'd3, 8'hAA, 8'hF0, 8'hA5, 1'b0, 16'h0008, "mwr3");
    xact(1'b0, 4'd3, 8'h00, 8'h00, 8'hA5, 1'b0, 16'h0008, "mrd3");
    xact(1'b1, 4'd3, 8'hFF, 8'h00, 8'hA5, 1'b0, 16'h0008, "zmask3");
    xact(1'b1, 4'd15, 8'hC3, 8'hFF, 8'hC3, 1'b0, 16'h8000, "wr15");
    xact(1'b0, 4'd14, 8'h00, 8'h00, 8'h00, 1'b0, 16'h4000, "rd14");
    xact(1'b0, 4'd15, 8'h00, 8'h00, 8'hC3, 1'b0, 16'h8000, "rd15");

    // Backpressure: response held while a second request waits on the bus.
    @(negedge clk);
    rspReady = 1'b0;
    reqValid = 1'b1; reqRw = 1'b0; reqAddr = 4'd3; reqWdata = 8'h00; reqWmask = 8'h00;
    @(negedge clk);
    reqRw = 1'b1; reqAddr = 4'd5; reqWdata = 8'h11; reqWmask = 8'hFF;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(rv16), 32'd1);
      check("bp_data", 32'(rd16), 32'hA5);
      check("bp_err", 32'(re16), 32'd0);
      check("bp_ready", 32'(rdy16), 32'd0);
      check("bp_wl", 32'(wl16), 32'd0);
      @(negedge clk);
    end
    rspReady = 1'b1;
    @(negedge clk);
    check("bp_idle_ready", 32'(rdy16), 32'd1);
    check("bp_idle_valid", 32'(rv16), 32'd0);
    @(negedge clk);
    reqValid = 1'b0;
    check("bp2_pre_ready", 32'(rdy16), 32'd0);
    @(negedge clk);
    check("bp2_acc_wl", 32'(wl16), 32'h0020);
    @(negedge clk);
    check("bp2_rsp_valid", 32'(rv16), 32'd1);
    check("bp2_rsp_data", 32'(rd16), 32'h11);
    @(negedge clk);
    check("bp2_end_ready", 32'(rdy16), 32'd1);
    xact(1'b0, 4'd5, 8'h00, 8'h00, 8'h11, 1'b0, 16'h0020, "rd5");

    // Out-of-range addresses on the 12-word bank.
    sel = 1'b1;
    xact(1'b1, 4'd13, 8'hFF, 8'hFF, 8'h00, 1'b1, 16'h0000, "oob13");
    xact(1'b0, 4'd12, 8'h00, 8'h00, 8'h00, 1'b1, 16'h0000, "oob12");
    xact(1'b0, 4'd1, 8'h00, 8'h00, 8'h00, 1'b0, 16'h0002, "d12_rd1");
    xact(1'b1, 4'd11, 8'h5A, 8'h0F, 8'h0A, 1'b0, 16'h0800, "d12_wr11");
    xact(1'b0, 4'd11, 8'h00, 8'h00, 8'h0A, 1'b0, 16'h0800, "d12_rd11");
    sel = 1'b0;

    // Reset during the ACCESS cycle of a write drops it entirely.
    @(negedge clk);
    reqValid = 1'b1; reqRw = 1'b1; reqAddr = 4'd7; reqWdata = 8'h3C; reqWmask = 8'hFF;
    @(negedge clk);
    reqValid = 1'b0;
    @(negedge clk);
    check("ra_acc_wl", 32'(wl16), 32'h0080);
    #1 rst = 1'b1;
    #1;
    check("ra_valid", 32'(rv16), 32'd0);
    check("ra_wl", 32'(wl16), 32'd0);
    check("ra_ready", 32'(rdy16), 32'd1);
    check("ra_data", 32'(rd16), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ra_post_valid", 32'(rv16), 32'd0);
    xact(1'b0, 4'd7, 8'h00, 8'h00, 8'h00, 1'b0, 16'h0080, "ra_rd7");
    xact(1'b0, 4'd3, 8'h00, 8'h00, 8'h00, 1'b0, 16'h0008, "ra_rd3");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
